// File: rtl/vec_store_unit_pkg.sv
// Shared definitions for the vector store unit.
//   NLANES  : number of vector lanes handled per store
//   LIW     : lane index width
//   MW      : lane-mask width
//   vs_state_t : controller states (idle, writing lanes, completion pulse)
package vec_store_unit_pkg;

  localparam int NLANES = 5;
  localparam int LIW    = 3;
  localparam int MW     = NLANES;

  typedef enum logic [1:0] {
    VS_IDLE  = 2'd0,
    VS_WRITE = 2'd1,
    VS_DONE  = 2'd2
  } vs_state_t;

endpackage

// File: rtl/vec_store_unit_lane_sel.sv
// Lane selector: combinational find-next-set-bit over the lane mask.
//   mask  : lane enable bits
//   from  : reference lane index
//   incl  : 1 -> search bits >= from, 0 -> search bits strictly above from
//   lane  : lowest qualifying set bit (0 when none)
//   found : a qualifying set bit exists
module vec_store_unit_lane_sel
  import vec_store_unit_pkg::*;
(
  input  logic [MW-1:0]  mask,
  input  logic [LIW-1:0] from,
  input  logic           incl,
  output logic [LIW-1:0] lane,
  output logic           found
);

  // Scan downward so the lowest qualifying lane is the last assignment.
  always_comb begin
    lane  = '0;
    found = 1'b0;
    for (int i = NLANES - 1; i >= 0; i--) begin
      if (mask[i] && ((LIW'(i) > from) || (incl && (LIW'(i) == from)))) begin
        lane  = LIW'(i);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/vec_store_unit.sv
// Vector store unit: captures five ALU lane results on start and writes the
// enabled lanes to data memory one word per req/ack transfer.
//   clk, reset          : clock, synchronous active-high reset
//   start               : begin a store (sampled only in idle)
//   base_addr, stride   : byte address of lane 0, byte distance between lanes
//   mask                : lane enables (bit i stores lane i)
//   res_0..res_4        : lane results, captured on the accepted start
//   mem_we/addr/wdata   : write request, held with stable address/data until mem_ack
//   mem_ack             : memory accepted the write this cycle
//   busy                : not idle
//   done                : one-cycle completion pulse
module vec_store_unit
  import vec_store_unit_pkg::*;
#(
  parameter int DW = 32,
  parameter int AW = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [AW-1:0] base_addr,
  input  logic [AW-1:0] stride,
  input  logic [4:0]    mask,
  input  logic [DW-1:0] res_0,
  input  logic [DW-1:0] res_1,
  input  logic [DW-1:0] res_2,
  input  logic [DW-1:0] res_3,
  input  logic [DW-1:0] res_4,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic          mem_ack,
  output logic          busy,
  output logic          done
);

  vs_state_t                    state_q, state_d;
  logic [LIW-1:0]               lane_q, lane_d;
  logic [MW-1:0]                mask_q;
  logic [AW-1:0]                base_q;
  logic [AW-1:0]                stride_q;
  logic [NLANES-1:0][DW-1:0]    res_q;
  logic [NLANES-1:0][DW-1:0]    res_in;
  logic                         capture;

  logic [LIW-1:0]               first_lane, next_lane;
  logic                         first_found, next_found;
  logic [AW-1:0]                lane_off;
  logic [DW-1:0]                lane_data;

  assign res_in[0] = res_0;
  assign res_in[1] = res_1;
  assign res_in[2] = res_2;
  assign res_in[3] = res_3;
  assign res_in[4] = res_4;

  // First lane comes straight from the live mask so WRITE can begin the
  // cycle after start; advances search the captured mask above the current lane.
  vec_store_unit_lane_sel u_first (
    .mask  (mask),
    .from  ('0),
    .incl  (1'b1),
    .lane  (first_lane),
    .found (first_found)
  );

  vec_store_unit_lane_sel u_next (
    .mask  (mask_q),
    .from  (lane_q),
    .incl  (1'b0),
    .lane  (next_lane),
    .found (next_found)
  );

  // lane*stride by shift/add; lane never exceeds 4. Wraps modulo 2^AW.
  always_comb begin
    lane_off = '0;
    case (lane_q)
      3'd1:    lane_off = stride_q;
      3'd2:    lane_off = stride_q << 1;
      3'd3:    lane_off = (stride_q << 1) + stride_q;
      3'd4:    lane_off = stride_q << 2;
      default: lane_off = '0;
    endcase
  end

  always_comb begin
    lane_data = '0;
    for (int i = 0; i < NLANES; i++) begin
      if (lane_q == LIW'(i)) lane_data = res_q[i];
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    lane_d  = lane_q;
    capture = 1'b0;
    case (state_q)
      VS_IDLE: begin
        if (start) begin
          capture = 1'b1;
          if (first_found) begin
            state_d = VS_WRITE;
            lane_d  = first_lane;
          end else begin
            state_d = VS_DONE;
          end
        end
      end
      VS_WRITE: begin
        if (mem_ack) begin
          if (next_found) lane_d  = next_lane;
          else            state_d = VS_DONE;
        end
      end
      VS_DONE:  state_d = VS_IDLE;
      default:  state_d = VS_IDLE;
    endcase
  end

  // Outputs: address/data are zero outside WRITE and depend only on
  // registered state inside it, so they stay stable through ack stalls.
  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    busy      = (state_q != VS_IDLE);
    done      = (state_q == VS_DONE);
    if (state_q == VS_WRITE) begin
      mem_we    = 1'b1;
      mem_addr  = base_q + lane_off;
      mem_wdata = lane_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= VS_IDLE;
      lane_q   <= '0;
      mask_q   <= '0;
      base_q   <= '0;
      stride_q <= '0;
      res_q    <= '0;
    end else begin
      state_q <= state_d;
      lane_q  <= lane_d;
      if (capture) begin
        mask_q   <= mask;
        base_q   <= base_addr;
        stride_q <= stride;
        res_q    <= res_in;
      end
    end
  end

endmodule
